// File: rtl/pc_fetch_unit.sv
// RV32 fetch stage: owns the PC, keeps one imem read in flight and hands {instr, pc, pc+4} to IF/ID.
// Latency gnt->if_valid_o is 2 cycles; a beat is held until if_ready_i, and redirects squash everything in flight.
module pc_fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [31:0]     if_instr_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_pc_plus4_o
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_if_pc;
    logic [31:0]     r_instr;

    logic            w_redirect;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_xfer;
    logic            w_capture;
    logic            w_beat_done;

    // A redirect landing in IDLE has nothing to squash and is dropped.
    assign w_redirect    = redirect_valid_i && (r_state != S_IDLE);
    assign w_redirect_pc = redirect_pc_i & PC_MASK;
    assign w_xfer        = (r_state == S_HOLD) && if_ready_i && !redirect_valid_i;
    assign w_capture     = (r_state == S_WAIT) && imem_rvalid_i && !redirect_valid_i;
    assign w_beat_done   = (r_state == S_HOLD) && (if_ready_i || redirect_valid_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: w_next_state = S_REQ;
            S_REQ: begin
                // A grant that coincides with a redirect fetched the stale address.
                if (imem_gnt_i) begin
                    w_next_state = redirect_valid_i ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    w_next_state = redirect_valid_i ? S_REQ : S_HOLD;
                end else if (redirect_valid_i) begin
                    w_next_state = S_DROP;
                end
            end
            S_HOLD: begin
                if (if_ready_i || redirect_valid_i) begin
                    w_next_state = S_REQ;
                end
            end
            // The squashed response must drain before a new request may go out.
            S_DROP: begin
                if (imem_rvalid_i) begin
                    w_next_state = S_REQ;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req_o  = (r_state == S_REQ);
        imem_addr_o = r_pc;
        if_valid_o  = (r_state == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_if_pc <= RESET_PC;
            r_instr <= NOP_INSTR;
        end else begin
            if (w_redirect) begin
                r_pc <= w_redirect_pc;
            end else if (w_xfer) begin
                r_pc <= r_pc + PC_STEP;
            end

            if (w_capture) begin
                r_instr <= imem_rdata_i;
                r_if_pc <= r_pc;
            end else if (w_beat_done) begin
                r_instr <= NOP_INSTR;
            end
        end
    end

    assign if_instr_o    = r_instr;
    assign if_pc_o       = r_if_pc;
    assign if_pc_plus4_o = r_if_pc + PC_STEP;

endmodule
